// File: rtl/flt_cmp.sv
// rtl/flt_cmp.sv - binary32 lt/le/eq comparator, one output register stage
// Optional invalid flag port nv is built when FLT_CMP_NV_EN is defined.
module flt_cmp (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [1:0]  op,
   input  logic [31:0] x1,
   input  logic [31:0] x2,
   output logic        out_valid,
   output logic        y
`ifdef FLT_CMP_NV_EN
   ,
   output logic        nv
`endif
);

   localparam logic [1:0] OP_LT = 2'b00;
   localparam logic [1:0] OP_LE = 2'b01;
   localparam logic [1:0] OP_EQ = 2'b10;

   logic [30:0] mag1, mag2;
   logic        sign1, sign2;
   logic        nan1, nan2, any_nan;
   logic        zero_both, eq, lt;
   logic        y_next;

   assign mag1  = x1[30:0];
   assign mag2  = x2[30:0];
   assign sign1 = x1[31];
   assign sign2 = x2[31];

   assign nan1    = (x1[30:23] == 8'hff) && (x1[22:0] != 23'd0);
   assign nan2    = (x2[30:23] == 8'hff) && (x2[22:0] != 23'd0);
   assign any_nan = nan1 | nan2;

   // Sign-magnitude layout lets the unsigned magnitude order stand in for
   // the float order within one sign; negatives simply reverse it.
   assign zero_both = (mag1 == 31'd0) && (mag2 == 31'd0);
   assign eq        = zero_both || (x1 == x2);

   always_comb begin
      lt = 1'b0;
      if (zero_both)
         lt = 1'b0;
      else if (sign1 != sign2)
         lt = sign1;
      else if (!sign1)
         lt = (mag1 < mag2);
      else
         lt = (mag1 > mag2);
   end

   always_comb begin
      y_next = 1'b0;
      case (op)
         OP_LT:   y_next = !any_nan && lt;
         OP_LE:   y_next = !any_nan && (lt || eq);
         OP_EQ:   y_next = !any_nan && eq;
         default: y_next = 1'b0;
      endcase
   end

`ifdef FLT_CMP_NV_EN
   logic any_snan, nv_next;

   // A quiet NaN has the top mantissa bit set; only signalling NaNs trap on eq.
   assign any_snan = (nan1 && !x1[22]) || (nan2 && !x2[22]);

   always_comb begin
      nv_next = 1'b0;
      case (op)
         OP_LT, OP_LE: nv_next = any_nan;
         OP_EQ:        nv_next = any_snan;
         default:      nv_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         nv <= 1'b0;
      else if (in_valid)
         nv <= nv_next;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         y         <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid)
            y <= y_next;
      end
   end

endmodule

// File: tb/tb_flt_cmp.sv
// tb/tb_flt_cmp.sv - randomized self-checking bench for flt_cmp against a real-valued model
// Checks nv as well when FLT_CMP_NV_EN is defined.
module tb_flt_cmp;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  op;
   logic [31:0] x1, x2;
   logic        out_valid;
   logic        y;
`ifdef FLT_CMP_NV_EN
   logic        nv;
`endif

   int checks   = 0;
   int failures = 0;
   logic exp_y_q  = 1'b0;
   logic exp_nv_q = 1'b0;

   always #5 clk = ~clk;

   flt_cmp dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .op        (op),
      .x1        (x1),
      .x2        (x2),
      .out_valid (out_valid),
      .y         (y)
`ifdef FLT_CMP_NV_EN
      ,
      .nv        (nv)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h (x1=%08h x2=%08h op=%0d)", tag, got, want, x1, x2, op);
      end
   endtask

   function automatic logic is_nan(input logic [31:0] b);
      return (b[30:23] == 8'd255) && (b[22:0] != 0);
   endfunction

   // Decode to the real number it denotes; infinities map beyond any finite float.
   function automatic real fval(input logic [31:0] b);
      real mag;
      int  e;
      e = int'(b[30:23]);
      if (e == 255)
         mag = 1.0e300;
      else if (e == 0)
         mag = real'(b[22:0]) * (2.0 ** (-149.0));
      else
         mag = (real'(b[22:0]) + 8388608.0) * (2.0 ** (real'(e) - 150.0));
      return b[31] ? -mag : mag;
   endfunction

   task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic ey, output logic env);
      real ra, rb;
      logic anan, snan;
      anan = is_nan(a) || is_nan(b);
      snan = (is_nan(a) && !a[22]) || (is_nan(b) && !b[22]);
      ra = fval(a);
      rb = fval(b);
      ey = 1'b0;
      env = 1'b0;
      if (!anan) begin
         case (o)
            2'd0: ey = (ra < rb);
            2'd1: ey = (ra <= rb);
            2'd2: ey = (ra == rb);
            default: ey = 1'b0;
         endcase
      end
      case (o)
         2'd0, 2'd1: env = anan;
         2'd2:       env = snan;
         default:    env = 1'b0;
      endcase
   endtask

   // One clock cycle: drive at negedge, check the registered result just after posedge.
   task automatic step(input string tag, input logic v, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input int want_y, input int want_nv);
      logic ey, env;
      in_valid = v;
      op = o;
      x1 = a;
      x2 = b;
      model(o, a, b, ey, env);
      if (v) begin
         exp_y_q  = ey;
         exp_nv_q = env;
      end
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
      check({tag, ".y"}, 32'(y), 32'(exp_y_q));
      if (v && want_y >= 0)
         check({tag, ".y_const"}, 32'(y), 32'(want_y));
`ifdef FLT_CMP_NV_EN
      check({tag, ".nv"}, 32'(nv), 32'(exp_nv_q));
      if (v && want_nv >= 0)
         check({tag, ".nv_const"}, 32'(nv), 32'(want_nv));
`endif
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_val();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 7))
         0: r[30:0] = 31'd0;
         1: r[30:0] = {8'hff, 23'd0};
         2: r[30:23] = 8'hff;
         3: r[30:23] = 8'd0;
         default: ;
      endcase
      return r;
   endfunction

   logic [22:0] edge_man [7] = '{23'h0, 23'h1, 23'h2, 23'h380000, 23'h400000, 23'h5fffff, 23'h7fffff};

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      op = 2'd0;
      x1 = 32'd0;
      x2 = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.y", 32'(y), 32'd0);
`ifdef FLT_CMP_NV_EN
      check("reset.nv", 32'(nv), 32'd0);
`endif
      rst = 1'b0;

      step("pos_lt",    1, 2'd0, 32'h3F800000, 32'h40000000, 1, 0);
      step("pos_lt_sw", 1, 2'd0, 32'h40000000, 32'h3F800000, 0, 0);
      step("zero_lt",   1, 2'd0, 32'h80000000, 32'h00000000, 0, 0);
      step("zero_le",   1, 2'd1, 32'h80000000, 32'h00000000, 1, 0);
      step("zero_eq",   1, 2'd2, 32'h80000000, 32'h00000000, 1, 0);
      step("neg_lt",    1, 2'd0, 32'hC0000000, 32'hBF800000, 1, 0);
      step("neg_lt_m",  1, 2'd0, 32'hBF800001, 32'hBF800000, 1, 0);
      step("sub_lt1",   1, 2'd0, 32'h00000001, 32'h00000002, 1, 0);
      step("sub_lt2",   1, 2'd0, 32'h807FFFFF, 32'h00000001, 1, 0);
      step("sub_lt3",   1, 2'd0, 32'h00800000, 32'h007FFFFF, 0, 0);
      step("qnan_lt",   1, 2'd0, 32'h7FC00000, 32'h3F800000, 0, 1);
      step("qnan_le",   1, 2'd1, 32'h7FC00000, 32'h3F800000, 0, 1);
      step("qnan_eq",   1, 2'd2, 32'h7FC00000, 32'h3F800000, 0, 0);
      step("snan_eq",   1, 2'd2, 32'h7F800001, 32'h7F800001, 0, 1);
      step("inf_le",    1, 2'd1, 32'h7F800000, 32'h7F800000, 1, 0);
      step("op3",       1, 2'd3, 32'h3F800000, 32'h3F800000, 0, 0);
      step("idle_hold", 0, 2'd0, 32'h3F800000, 32'h40000000, -1, -1);
      step("b2b_0",     1, 2'd0, 32'h3F800000, 32'h40000000, 1, 0);
      step("b2b_1",     1, 2'd0, 32'h40000000, 32'h3F800000, 0, 0);
      step("b2b_2",     1, 2'd1, 32'h40000000, 32'h40000000, 1, 0);

      // Asynchronous reset between edges, with a valid input pending across the edge.
      step("pre_rst",   1, 2'd0, 32'h3F800000, 32'h40000000, 1, 0);
      in_valid = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst.out_valid", 32'(out_valid), 32'd0);
      check("async_rst.y", 32'(y), 32'd0);
`ifdef FLT_CMP_NV_EN
      check("async_rst.nv", 32'(nv), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      exp_y_q  = 1'b0;
      exp_nv_q = 1'b0;
      step("post_rst",  0, 2'd0, 32'h3F800000, 32'h40000000, -1, -1);

      for (int e = 0; e < 255; e++) begin
         for (int s = 0; s < 2; s++) begin
            for (int m = 0; m < 8; m++) begin
               logic [31:0] a, b;
               logic [22:0] man;
               man = (m < 7) ? edge_man[m] : 23'($urandom);
               a = {s[0], e[7:0], man};
               case ($urandom_range(0, 3))
                  0: b = a + 32'd1;
                  1: b = a - 32'd1;
                  2: b = a ^ 32'h80000000;
                  default: b = {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
               endcase
               if ($urandom_range(0, 1) == 1) begin
                  logic [31:0] t;
                  t = a; a = b; b = t;
               end
               step("sweep", 1'($urandom_range(0, 7) != 0), 2'($urandom_range(0, 2)), a, b, -1, -1);
            end
         end
      end

      for (int i = 0; i < 3000; i++) begin
         logic [31:0] a, b;
         a = rand_val();
         b = ($urandom_range(0, 5) == 0) ? a : rand_val();
         step("random", 1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), a, b, -1, -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flt_cmp.md
Name: flt_cmp

Overview:
- Single-precision (IEEE-754 binary32) floating-point comparator for the FPU.
- Performs less-than, less-or-equal and equal on two operands and returns a 1-bit result one clock cycle later.
- Used by the core's FLT/FLE/FEQ instructions.
- The comparison core is purely combinational, with a single output register stage and a valid handshake.

Parameters:
- None.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands and op are valid this cycle.
- op  input  2  operation select: 00 = lt, 01 = le, 10 = eq, 11 = reserved.
- x1  input  32  operand 1, binary32: sign [31], exponent [30:23], mantissa [22:0].
- x2  input  32  operand 2, binary32, same layout.
- out_valid  output  1  y (and nv) valid this cycle.
- y  output  1  comparison result.
- nv  output  1  invalid-operation flag; present only with FLT_CMP_NV_EN.

Behaviour:
- Reset:
  - While rst is high: out_valid=0, y=0, nv=0, taking effect immediately (asynchronous).
  - rst asserted mid-operation discards the in-flight result; no out_valid is produced for it.
- Latency and handshake:
  - Fixed latency of 1 cycle, no backpressure.
  - On a rising edge with in_valid=1: y and nv are registered from the current inputs and out_valid becomes 1.
  - On a rising edge with in_valid=0: out_valid becomes 0 and y/nv hold their previous values.
  - Back-to-back inputs give back-to-back results.
- Combinational compare:
  - mag1 = x1[30:0], mag2 = x2[30:0], compared as unsigned integers. This orders normals, subnormals and infinities correctly.
  - zero_both = (mag1==0) and (mag2==0). +0 and -0 are equal.
  - eq = zero_both or (x1==x2).
  - lt rules, in order:
    - if zero_both, lt = 0;
    - else if the signs differ, lt = x1[31];
    - else if both are positive, lt = (mag1 < mag2);
    - else (both negative), lt = (mag1 > mag2).
  - le = lt or eq.
- NaN handling:
  - NaN is exponent 255 with mantissa != 0.
  - If either operand is NaN, y=0 for every op.
  - Infinity (exponent 255, mantissa 0) compares as an ordinary value.
- Subnormals (exponent 0) are compared exactly; they are never flushed.
- op=11 gives y=0 and nv=0.
- Result must exactly match IEEE-754 ordered comparison over all 2^64 input pairs.

Optional Feature:
- Macro FLT_CMP_NV_EN.
- When defined, port nv exists:
  - lt/le: nv=1 if either operand is any NaN;
  - eq: nv=1 only if either operand is a signalling NaN (mantissa[22]=0, mantissa != 0);
  - otherwise nv=0.
  - nv is registered with y and is 0 after reset.
- When not defined, the nv port and its logic are absent. y/out_valid behaviour is identical in both builds.

Test Plan:
- Positive ordering: x1=0x3F800000 (1.0), x2=0x40000000 (2.0), op=lt, in_valid=1 -> next cycle out_valid=1, y=1. Swap operands -> y=0.
- Signed zero: x1=0x80000000, x2=0x00000000 -> lt gives y=0, le gives y=1, eq gives y=1.
- Negatives: x1=0xC0000000 (-2), x2=0xBF800000 (-1), lt -> y=1. Same-exponent negatives x1=0xBF800001, x2=0xBF800000, lt -> y=1.
- Subnormals:
  - 0x00000001 vs 0x00000002, lt -> y=1;
  - 0x807FFFFF vs 0x00000001, lt -> y=1;
  - 0x00800000 vs 0x007FFFFF, lt -> y=0.
- NaN: x1=0x7FC00000, x2=0x3F800000 -> lt/le/eq all give y=0.
  - With FLT_CMP_NV_EN: lt gives nv=1; eq gives nv=0.
  - With FLT_CMP_NV_EN and x1=0x7F800001: eq gives nv=1.
- Handshake/reset:
  - in_valid pulses on 3 consecutive cycles -> out_valid high on 3 consecutive cycles, each y correct.
  - rst raised between clock edges -> out_valid, y (and nv when FLT_CMP_NV_EN is defined) are 0 immediately.
  - Exhaustive sweep over exponents 0..254, both signs, edge mantissas (0, 1, 2, 0x380000, 0x400000, 0x5FFFFF, 0x7FFFFF) and random mantissas -> y matches the IEEE compare.
